// File: rtl/vga_pkg.sv
// 640x480@60 timing constants shared with the sync generator, plus the
// lock state type used by the receive-side timing decoder.
package vga_pkg;

    localparam int VGA_HPIXELS         = 640;
    localparam int VGA_HSPULSE         = 96;
    localparam int VGA_MAX_HCOUNT      = 800;
    localparam int VGA_VLINES          = 480;
    localparam int VGA_VSPULSE         = 2;
    localparam int VGA_MAX_VCOUNT      = 521;
    localparam int VGA_HSYNC_START_COL = 657;
    localparam int VGA_VSYNC_START_ROW = 490;
    localparam int VGA_VSYNC_START_COL = 0;
    localparam int VGA_LOCK_FRAMES     = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

endpackage

// File: rtl/vga_timing_decoder_sync_edge_det.sv
// Edge strobes for an active-low sync line; the idle level is high, so the
// previous-sample register resets to 1 and a sync held low out of reset
// reads as a falling edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_fall,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= 1'b1;
        else     r_q <= i_sync;
    end

    assign o_fall = r_q & ~i_sync;
    assign o_rise = ~r_q & i_sync;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers column/row/pixel-valid from active-low HSYNC/VSYNC and qualifies
// the timing with a SEARCH/ALIGN/LOCKED machine. Optional error counter: VGA_DEC_STATS_EN.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int HPIXELS         = VGA_HPIXELS,
    parameter int HSPULSE         = VGA_HSPULSE,
    parameter int MAX_HCOUNT      = VGA_MAX_HCOUNT,
    parameter int VLINES          = VGA_VLINES,
    parameter int VSPULSE         = VGA_VSPULSE,
    parameter int MAX_VCOUNT      = VGA_MAX_VCOUNT,
    parameter int HSYNC_START_COL = VGA_HSYNC_START_COL,
    parameter int VSYNC_START_ROW = VGA_VSYNC_START_ROW,
    parameter int VSYNC_START_COL = VGA_VSYNC_START_COL,
    parameter int LOCK_FRAMES     = VGA_LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [9:0] o_col,
    output logic [9:0] o_row,
    output logic       o_pix_valid,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_err
`ifdef VGA_DEC_STATS_EN
    ,
    output logic [15:0] o_err_cnt
`endif
);

    localparam int FCW = $clog2(LOCK_FRAMES + 1);

    localparam logic [9:0] L_HLAST   = 10'(MAX_HCOUNT - 1);
    localparam logic [9:0] L_VLAST   = 10'(MAX_VCOUNT - 1);
    localparam logic [9:0] L_HS_FALL = 10'(HSYNC_START_COL);
    localparam logic [9:0] L_HS_LOAD = 10'((HSYNC_START_COL + 1) % MAX_HCOUNT);
    localparam logic [9:0] L_HS_RISE = 10'((HSYNC_START_COL + HSPULSE) % MAX_HCOUNT);
    localparam logic [9:0] L_VS_ROW  = 10'(VSYNC_START_ROW);
    localparam logic [9:0] L_VS_RROW = 10'(VSYNC_START_ROW + VSPULSE);
    localparam logic [9:0] L_VS_COL  = 10'(VSYNC_START_COL);
    localparam logic [9:0] L_HPIX    = 10'(HPIXELS);
    localparam logic [9:0] L_VLIN    = 10'(VLINES);
    localparam logic [FCW-1:0] L_LOCK = FCW'(LOCK_FRAMES);

    dec_state_t     r_state, w_state_nxt;
    logic [9:0]     r_hcnt, r_vcnt, w_hcnt_nxt, w_vcnt_nxt, w_hinc, w_vinc;
    logic [FCW-1:0] r_frame_cnt, w_fc_nxt, w_fc_inc;
    logic           r_locked, r_err, w_err_nxt;
    logic           w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
    logic           w_hwrap, w_vs_spot, w_viol;

    sync_edge_det u_hs_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sync (i_hsync),
        .o_fall (w_hs_fall),
        .o_rise (w_hs_rise)
    );

    sync_edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sync (i_vsync),
        .o_fall (w_vs_fall),
        .o_rise (w_vs_rise)
    );

    assign w_hwrap   = (r_hcnt == L_HLAST);
    assign w_hinc    = w_hwrap ? 10'd0 : r_hcnt + 10'd1;
    assign w_vinc    = (r_vcnt == L_VLAST) ? 10'd0 : r_vcnt + 10'd1;
    assign w_fc_inc  = r_frame_cnt + FCW'(1);
    assign w_vs_spot = (r_vcnt == L_VS_ROW) && (r_hcnt == L_VS_COL);

    // Any mismatch between the sync edges and the free-running counters.
    assign w_viol = (w_hs_fall && (r_hcnt != L_HS_FALL))
                  | ((r_hcnt == L_HS_FALL) && !w_hs_fall)
                  | (w_hs_rise && (r_hcnt != L_HS_RISE))
                  | (w_vs_fall && !w_vs_spot)
                  | (w_vs_spot && !w_vs_fall)
                  | (w_vs_rise && !((r_vcnt == L_VS_RROW) && (r_hcnt == L_VS_COL)));

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = w_hinc;
        w_vcnt_nxt  = r_vcnt;
        w_fc_nxt    = r_frame_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            SEARCH: begin
                w_vcnt_nxt = 10'd0;
                if (w_hs_fall) w_hcnt_nxt = L_HS_LOAD;
                if (w_vs_fall) begin
                    w_vcnt_nxt  = L_VS_ROW;
                    w_fc_nxt    = '0;
                    w_state_nxt = ALIGN;
                end
            end
            default: begin
                if (w_hwrap) w_vcnt_nxt = w_vinc;
                if (w_viol) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = SEARCH;
                    w_vcnt_nxt  = 10'd0;
                end else if ((r_state == ALIGN) && w_vs_fall) begin
                    w_fc_nxt = w_fc_inc;
                    if (w_fc_inc == L_LOCK) w_state_nxt = LOCKED;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_hcnt      <= 10'd0;
            r_vcnt      <= 10'd0;
            r_frame_cnt <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_vcnt      <= w_vcnt_nxt;
            r_frame_cnt <= w_fc_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err       <= w_err_nxt;
        end
    end

    assign o_col         = r_hcnt;
    assign o_row         = r_vcnt;
    assign o_locked      = r_locked;
    assign o_err         = r_err;
    assign o_pix_valid   = r_locked && (r_hcnt < L_HPIX) && (r_vcnt < L_VLIN);
    assign o_frame_start = r_locked && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

`ifdef VGA_DEC_STATS_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_err_cnt <= 16'd0;
        else if (r_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign o_err_cnt = r_err_cnt;
`endif

endmodule
